bin2rns_seq: RTL and testbench

BIN2RNS_SEQ -- requirements
Module: bin2rns_seq

---
 rtl/rns_pkg.sv | 13 +
 rtl/bin2rns_seq_if.sv | 28 ++
 rtl/rns_chunk_step.sv | 24 ++
 rtl/bin2rns_seq.sv | 111 +++++++++++
 tb/tb_bin2rns_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rns_pkg.sv
// Shared definitions for the sequential binary-to-RNS converter:
// FSM encoding, default geometry and the default modulus set.
package rns_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHUNK    = 4;
    localparam int DEF_MOD_SIZE = 3;
    localparam int DEF_N_MOD    = 4;

    // Channel 0 in the low nibble: moduli (8, 7, 5, 3)
    localparam logic [DEF_N_MOD*(DEF_MOD_SIZE+1)-1:0] DEF_MODULI = {4'd3, 4'd5, 4'd7, 4'd8};
endpackage

// File: rtl/bin2rns_seq_if.sv
// Operand/result handshake bundle; slave is the converter, master the client.
interface bin2rns_seq_if
    import rns_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MOD_SIZE = DEF_MOD_SIZE,
    parameter int N_MOD    = DEF_N_MOD
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic                          in_signed;
    logic [N_MOD*(MOD_SIZE+1)-1:0] moduli;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_MOD*MOD_SIZE-1:0]     out_res;
    logic [N_MOD-1:0]              out_err;

    modport slave (
        input  in_valid, in_data, in_signed, moduli, out_ready,
        output in_ready, out_valid, out_res, out_err
    );

    modport master (
        output in_valid, in_data, in_signed, moduli, out_ready,
        input  in_ready, out_valid, out_res, out_err
    );
endinterface

// File: rtl/rns_chunk_step.sv
// One channel, one chunk: CHUNK unrolled steps of r = 2r + bit, reduced by m.
module rns_chunk_step #(
    parameter int CHUNK    = 4,
    parameter int MOD_SIZE = 3
) (
    input  logic [MOD_SIZE:0]   m,
    input  logic [MOD_SIZE-1:0] r_in,
    input  logic [CHUNK-1:0]    bits,
    output logic [MOD_SIZE-1:0] r_out
);
    logic [MOD_SIZE:0] t;

    // r < m <= 2^MOD_SIZE, so 2r+bit needs one extra bit before the reduction
    always_comb begin
        t     = '0;
        r_out = r_in;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            t = {r_out, bits[i]};
            if (t >= m)
                t = t - m;
            r_out = t[MOD_SIZE-1:0];
        end
    end
endmodule

// File: rtl/bin2rns_seq.sv
// Sequential binary-to-RNS converter: CHUNK bits per cycle, MSB first,
// followed by a one-cycle sign fix-up for negative two's-complement operands.
module bin2rns_seq
    import rns_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHUNK    = DEF_CHUNK,
    parameter int MOD_SIZE = DEF_MOD_SIZE,
    parameter int N_MOD    = DEF_N_MOD
) (
    input logic          clk,
    input logic          reset,
    bin2rns_seq_if.slave bus
);
    localparam int NCH   = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [MOD_SIZE:0] M_MIN = (MOD_SIZE+1)'(2);
    localparam logic [MOD_SIZE:0] M_MAX = {1'b1, {MOD_SIZE{1'b0}}};

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("bin2rns_seq: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
    end

    state_t state, state_nxt;

    logic [WIDTH-1:0]                   mag, in_mag;
    logic                               sgn, msb, in_neg;
    logic [N_MOD-1:0][MOD_SIZE:0]       mods;
    logic [N_MOD-1:0][MOD_SIZE-1:0]     res, res_step, res_fix;
    logic [N_MOD-1:0]                   err, err_in;
    logic [CNT_W-1:0]                   cnt;
    logic                               accept, last;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CNT_W'(NCH - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_res   = res;
    assign bus.out_err   = err;

    assign in_neg = bus.in_signed && bus.in_data[WIDTH-1];
    assign in_mag = in_neg ? -bus.in_data : bus.in_data;

    for (genvar k = 0; k < N_MOD; k++) begin : g_ch
        logic [MOD_SIZE:0] m_in;
        assign m_in      = bus.moduli[k*(MOD_SIZE+1) +: MOD_SIZE+1];
        assign err_in[k] = (m_in < M_MIN) || (m_in > M_MAX);
        assign res_fix[k] = MOD_SIZE'(mods[k] - {1'b0, res[k]});

        rns_chunk_step #(.CHUNK(CHUNK), .MOD_SIZE(MOD_SIZE)) u_step (
            .m    (mods[k]),
            .r_in (res[k]),
            .bits (mag[WIDTH-1 -: CHUNK]),
            .r_out(res_step[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mag  <= '0;
            sgn  <= 1'b0;
            msb  <= 1'b0;
            mods <= '0;
            res  <= '0;
            err  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mag  <= in_mag;
                    sgn  <= bus.in_signed;
                    msb  <= bus.in_data[WIDTH-1];
                    mods <= bus.moduli;
                    err  <= err_in;
                    res  <= '0;
                    cnt  <= '0;
                end
                RUN: begin
                    res <= res_step;
                    mag <= mag << CHUNK;
                    cnt <= cnt + 1'b1;
                end
                // Invalid channels are forced to 0 here rather than gated every RUN cycle
                FIX: for (int k = 0; k < N_MOD; k++) begin
                    if (err[k])
                        res[k] <= '0;
                    else if (sgn && msb && res[k] != '0)
                        res[k] <= res_fix[k];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2rns_seq.sv
// Directed + swept checks of bin2rns_seq against spec constants and an integer % model.
module tb_bin2rns_seq;
    import rns_pkg::*;

    typedef struct packed {
        logic [11:0] res;
        logic [3:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2rns_seq_if bus ();
    bin2rns_seq dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb[$];
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int r0, r1, r2, r3, input logic [3:0] e);
        exp_t x;
        x.res = {3'(r3), 3'(r2), 3'(r1), 3'(r0)};
        x.err = e;
        return x;
    endfunction

    // Integer reference: mathematical value mod m, 0 <= r < m
    function automatic exp_t model(input logic [31:0] d, input logic s, input logic [15:0] mods);
        exp_t   x;
        longint v, r;
        int     m;
        if (s) v = $signed(d);
        else   v = longint'(d);
        x = '0;
        for (int k = 0; k < 4; k++) begin
            m = int'(mods[k*4 +: 4]);
            if (m < 2 || m > 8) begin
                x.err[k] = 1'b1;
            end else begin
                r = v % m;
                if (r < 0) r = r + m;
                x.res[k*3 +: 3] = 3'(r);
            end
        end
        return x;
    endfunction

    task automatic do_op(input logic [31:0] d, input logic s, input logic [15:0] mods,
                         input exp_t e, input int hold, input string tag);
        exp_t exp_v;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        bus.in_data   = d;
        bus.in_signed = s;
        bus.moduli    = mods;
        bus.in_valid  = 1'b1;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        // Scramble inputs after accept; the latched copy must be used
        bus.in_valid  = 1'b0;
        bus.in_data   = $urandom;
        bus.in_signed = ~s;
        bus.moduli    = 16'h0000;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        exp_v = sb.pop_front();
        check({tag, " out_res"}, 64'(bus.out_res), 64'(exp_v.res));
        check({tag, " out_err"}, 64'(bus.out_err), 64'(exp_v.err));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.moduli   = DEF_MODULI;
            @(negedge clk);
            check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, " hold res"}, 64'({bus.out_res, bus.out_err}), 64'({exp_v.res, exp_v.err}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " retired"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    initial begin
        int seen;
        logic [31:0] d;
        logic [15:0] m;
        logic        s;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.moduli    = DEF_MODULI;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_res",   64'(bus.out_res),   64'd0);
        check("reset out_err",   64'(bus.out_err),   64'd0);
        reset = 1'b0;

        do_op(32'd419, 1'b0, DEF_MODULI, mk(3, 6, 4, 2, 4'b0000), 0, "u419");
        do_op(-32'sd420, 1'b1, DEF_MODULI, mk(4, 0, 0, 0, 4'b0000), 0, "s-420");
        do_op(32'hFFFF_FFFF, 1'b1, DEF_MODULI, mk(7, 6, 4, 2, 4'b0000), 0, "s-1");
        do_op(32'hFFFF_FFFF, 1'b0, DEF_MODULI, mk(7, 3, 0, 0, 4'b0000), 0, "uFFFFFFFF");
        do_op(32'h8000_0000, 1'b1, DEF_MODULI, model(32'h8000_0000, 1'b1, DEF_MODULI), 0, "s-2^31");
        do_op(32'd13, 1'b0, {4'd9, 4'd5, 4'd1, 4'd8}, mk(5, 0, 3, 0, 4'b1010), 0, "badmod");
        do_op(32'd77, 1'b0, DEF_MODULI, model(32'd77, 1'b0, DEF_MODULI), 5, "stall");

        // Abort mid-RUN: reset lands in the 4th RUN cycle
        @(negedge clk);
        bus.in_data  = 32'd100;
        bus.moduli   = DEF_MODULI;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort state", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        check("abort regs",  64'({bus.out_res, bus.out_err}),    64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("abort no result", 64'(seen), 64'd0);
        do_op(32'd5, 1'b0, DEF_MODULI, mk(5, 5, 0, 2, 4'b0000), 0, "after abort");

        for (int v = -420; v <= 419; v++)
            do_op(32'(v), 1'b1, DEF_MODULI, model(32'(v), 1'b1, DEF_MODULI), 0, "sweep");

        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            m = 16'($urandom);
            s = 1'($urandom);
            do_op(d, s, m, model(d, s, m), 0, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
